// File: rtl/bitsim_pkg.sv
// rtl/bitsim_pkg.sv - shared types for the bit scan encoder
package bitsim_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

endpackage

// File: rtl/bit_scan_encoder_if.sv
// rtl/bit_scan_encoder_if.sv - mask-in / index-out handshake bundle
interface bit_scan_encoder_if #(
  parameter int WIDTH = 16
);
  localparam int IDXW = $clog2(WIDTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_mask;
  logic             out_valid;
  logic             out_ready;
  logic [IDXW-1:0]  out_idx;
  logic             out_last;
  logic             out_empty;

  modport master (
    output in_valid, in_mask, out_ready,
    input  in_ready, out_valid, out_idx, out_last, out_empty
  );

  modport slave (
    input  in_valid, in_mask, out_ready,
    output in_ready, out_valid, out_idx, out_last, out_empty
  );
endinterface

// File: rtl/pri_encoder_w.sv
// rtl/pri_encoder_w.sv - combinational priority encoder, selectable scan direction
module pri_encoder_w #(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic [WIDTH-1:0]         vec,
  output logic [$clog2(WIDTH)-1:0] index,
  output logic                     zero
);
  localparam int IDXW = $clog2(WIDTH);

  // Later matches overwrite earlier ones, so loop direction picks the winner.
  always_comb begin
    index = '0;
    zero  = ~|vec;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (vec[i]) index = IDXW'(i);
      end
    end else begin
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (vec[i]) index = IDXW'(i);
      end
    end
  end
endmodule

// File: rtl/bit_scan_encoder.sv
// rtl/bit_scan_encoder.sv - emits the set-bit indices of a mask one beat at a time
module bit_scan_encoder
  import bitsim_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int MSB_FIRST = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  bit_scan_encoder_if.slave  bus,
  output logic               busy
);
  localparam int IDXW = $clog2(WIDTH);

  scan_state_t      state, state_nxt;
  logic [WIDTH-1:0] work, work_nxt;
  logic [IDXW-1:0]  enc_idx;
  logic             enc_zero;
  logic             at_most_one;
  logic             scanning;
  logic             last_beat;

  pri_encoder_w #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_enc (
    .vec   (work),
    .index (enc_idx),
    .zero  (enc_zero)
  );

  // Clearing the lowest set bit leaves zero iff at most one bit was set.
  assign at_most_one = (work & (work - WIDTH'(1))) == '0;
  assign scanning    = (state == SCAN);
  assign last_beat   = scanning & at_most_one;

  assign busy          = scanning;
  assign bus.out_valid = scanning;
  assign bus.out_last  = last_beat;
  assign bus.out_empty = scanning & enc_zero;
  assign bus.out_idx   = scanning ? enc_idx : '0;
  assign bus.in_ready  = !scanning | (bus.out_ready & last_beat);

  always_comb begin
    state_nxt = state;
    work_nxt  = work;
    case (state)
      IDLE: begin
        if (bus.in_valid) begin
          state_nxt = SCAN;
          work_nxt  = bus.in_mask;
        end
      end
      SCAN: begin
        if (bus.out_ready) begin
          if (last_beat) begin
            if (bus.in_valid) begin
              work_nxt = bus.in_mask;
            end else begin
              state_nxt = IDLE;
              work_nxt  = '0;
            end
          end else begin
            work_nxt[enc_idx] = 1'b0;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      work  <= '0;
    end else begin
      state <= state_nxt;
      work  <= work_nxt;
    end
  end
endmodule

// File: tb/tb_bit_scan_encoder.sv
// tb/tb_bit_scan_encoder.sv - scoreboard bench: 16-bit MSB/LSB pair plus a 64-bit instance
module tb_bit_scan_encoder;

  typedef struct {
    int   idx;
    logic last;
    logic empty;
  } beat_t;

  typedef struct {
    logic [15:0] mask;
    int          beats;
    int          hi;
    int          lo;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic        in_valid16 = 1'b0;
  logic [15:0] in_mask16 = '0;
  logic        out_ready16 = 1'b1;
  logic        in_valid64 = 1'b0;
  logic [63:0] in_mask64 = '0;
  logic        out_ready64 = 1'b1;
  logic        busy_a, busy_b, busy_c;

  int    n_cmp = 0;
  int    n_fail = 0;
  beat_t qa[$];
  beat_t qb[$];
  beat_t qc[$];
  int    beats_a = 0, beats_b = 0, beats_c = 0;
  int    last_a = 0, last_b = 0;
  vec_t  tbl[8];

  always #5 clk = ~clk;

  bit_scan_encoder_if #(.WIDTH(16)) ifa ();
  bit_scan_encoder_if #(.WIDTH(16)) ifb ();
  bit_scan_encoder_if #(.WIDTH(64)) ifc ();

  assign ifa.in_valid  = in_valid16;
  assign ifa.in_mask   = in_mask16;
  assign ifa.out_ready = out_ready16;
  assign ifb.in_valid  = in_valid16;
  assign ifb.in_mask   = in_mask16;
  assign ifb.out_ready = out_ready16;
  assign ifc.in_valid  = in_valid64;
  assign ifc.in_mask   = in_mask64;
  assign ifc.out_ready = out_ready64;

  bit_scan_encoder #(.WIDTH(16), .MSB_FIRST(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa), .busy(busy_a));
  bit_scan_encoder #(.WIDTH(16), .MSB_FIRST(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb), .busy(busy_b));
  bit_scan_encoder #(.WIDTH(64), .MSB_FIRST(1)) dut_c (
    .clk(clk), .reset_n(reset_n), .bus(ifc), .busy(busy_c));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void push16(input logic [15:0] m);
    int n;
    int k;
    n = $countones(m);
    if (m == 16'h0) begin
      qa.push_back('{0, 1'b1, 1'b1});
      qb.push_back('{0, 1'b1, 1'b1});
    end else begin
      k = 0;
      for (int i = 15; i >= 0; i--) if (m[i]) begin k++; qa.push_back('{i, k == n, 1'b0}); end
      k = 0;
      for (int i = 0; i < 16; i++) if (m[i]) begin k++; qb.push_back('{i, k == n, 1'b0}); end
    end
  endfunction

  function automatic void push64(input logic [63:0] m);
    int n;
    int k;
    n = $countones(m);
    k = 0;
    if (m == 64'h0) qc.push_back('{0, 1'b1, 1'b1});
    else for (int i = 63; i >= 0; i--) if (m[i]) begin k++; qc.push_back('{i, k == n, 1'b0}); end
  endfunction

  // Scoreboard side: pop one expectation per completed beat.
  always @(negedge clk) begin
    beat_t e;
    if (ifa.out_valid && ifa.out_ready) begin
      beats_a++;
      last_a = int'(ifa.out_idx);
      check("a_beat_expected", 64'(qa.size() > 0), 64'd1);
      if (qa.size() > 0) begin
        e = qa.pop_front();
        check("a_idx", 64'(ifa.out_idx), 64'(e.idx));
        check("a_last", 64'(ifa.out_last), 64'(e.last));
        check("a_empty", 64'(ifa.out_empty), 64'(e.empty));
      end
    end
    if (ifb.out_valid && ifb.out_ready) begin
      beats_b++;
      last_b = int'(ifb.out_idx);
      check("b_beat_expected", 64'(qb.size() > 0), 64'd1);
      if (qb.size() > 0) begin
        e = qb.pop_front();
        check("b_idx", 64'(ifb.out_idx), 64'(e.idx));
        check("b_last", 64'(ifb.out_last), 64'(e.last));
        check("b_empty", 64'(ifb.out_empty), 64'(e.empty));
      end
    end
    if (ifc.out_valid && ifc.out_ready) begin
      beats_c++;
      check("c_beat_expected", 64'(qc.size() > 0), 64'd1);
      if (qc.size() > 0) begin
        e = qc.pop_front();
        check("c_idx", 64'(ifc.out_idx), 64'(e.idx));
        check("c_last", 64'(ifc.out_last), 64'(e.last));
        check("c_empty", 64'(ifc.out_empty), 64'(e.empty));
      end
    end
  end

  task automatic send16(input logic [15:0] m);
    int t;
    t = 0;
    @(posedge clk); #1;
    in_valid16 = 1'b1;
    in_mask16  = m;
    while (1) begin
      @(negedge clk);
      if (ifa.in_ready) break;
      t++;
      if (t > 100) begin
        check("a_accept_timeout", 64'(ifa.in_ready), 64'd1);
        break;
      end
    end
    push16(m);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    in_mask16  = 16'($urandom);
  endtask

  task automatic drain16();
    int t;
    t = 0;
    while ((qa.size() != 0 || qb.size() != 0) && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("ab_drained", 64'(qa.size() + qb.size()), 64'd0);
  endtask

  task automatic drain64();
    int t;
    t = 0;
    while (qc.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("c_drained", 64'(qc.size()), 64'd0);
  endtask

  initial begin
    int ba;
    int bc0;
    int t;

    tbl[0] = '{16'h8421, 4, 15, 0};
    tbl[1] = '{16'h0000, 1, 0, 0};
    tbl[2] = '{16'h0001, 1, 0, 0};
    tbl[3] = '{16'h8000, 1, 15, 15};
    tbl[4] = '{16'hFFFF, 16, 15, 0};
    tbl[5] = '{16'h0003, 2, 1, 0};
    tbl[6] = '{16'h5A5A, 8, 14, 1};
    tbl[7] = '{16'h0240, 2, 9, 6};

    #2 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(ifa.out_valid), 64'd0);
    check("rst_in_ready", 64'(ifa.in_ready), 64'd1);
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_out_idx", 64'(ifa.out_idx), 64'd0);
    check("rst_out_last", 64'(ifa.out_last), 64'd0);
    check("rst_out_empty", 64'(ifa.out_empty), 64'd0);
    check("rst_c_out_valid", 64'(ifc.out_valid), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      ba = beats_a;
      send16(tbl[v].mask);
      drain16();
      @(posedge clk);
      @(negedge clk);
      check("vec_busy_idle", 64'(busy_a), 64'd0);
      check("vec_beats", 64'(beats_a - ba), 64'(tbl[v].beats));
      check("vec_final_idx_msb", 64'(last_a), 64'(tbl[v].lo));
      check("vec_final_idx_lsb", 64'(last_b), 64'(tbl[v].hi));
    end

    // Stall on the first beat of 0x0003 for three cycles.
    out_ready16 = 1'b0;
    send16(16'h0003);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_a_idx", 64'(ifa.out_idx), 64'd1);
      check("stall_a_valid", 64'(ifa.out_valid), 64'd1);
      check("stall_a_in_ready", 64'(ifa.in_ready), 64'd0);
      check("stall_b_idx", 64'(ifb.out_idx), 64'd0);
    end
    @(posedge clk); #1;
    out_ready16 = 1'b1;
    @(negedge clk);
    check("stall_a_idx_4th", 64'(ifa.out_idx), 64'd1);
    drain16();
    @(posedge clk);
    @(negedge clk);
    check("stall_busy_idle", 64'(busy_a), 64'd0);

    // Back-to-back masks with in_valid held high.
    @(posedge clk); #1;
    in_valid16 = 1'b1;
    in_mask16  = 16'h0001;
    @(negedge clk);
    check("b2b_ready_idle", 64'(ifa.in_ready), 64'd1);
    push16(16'h0001);
    @(posedge clk); #1;
    in_mask16 = 16'h0100;
    @(negedge clk);
    check("b2b_first_idx", 64'(ifa.out_idx), 64'd0);
    check("b2b_first_last", 64'(ifa.out_last), 64'd1);
    check("b2b_ready_on_last", 64'(ifa.in_ready), 64'd1);
    push16(16'h0100);
    @(posedge clk); #1;
    in_valid16 = 1'b0;
    @(negedge clk);
    check("b2b_second_valid", 64'(ifa.out_valid), 64'd1);
    check("b2b_second_idx", 64'(ifa.out_idx), 64'd8);
    drain16();

    // 64-bit all-ones, reset after five beats.
    bc0 = beats_c;
    @(posedge clk); #1;
    in_valid64 = 1'b1;
    in_mask64  = 64'hFFFF_FFFF_FFFF_FFFF;
    @(negedge clk);
    check("c_ready_idle", 64'(ifc.in_ready), 64'd1);
    push64(64'hFFFF_FFFF_FFFF_FFFF);
    @(posedge clk); #1;
    in_valid64 = 1'b0;
    in_mask64  = '0;
    t = 0;
    while (beats_c - bc0 < 5 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("c_five_beats", 64'(beats_c - bc0), 64'd5);
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check("c_rst_out_valid", 64'(ifc.out_valid), 64'd0);
    check("c_rst_busy", 64'(busy_c), 64'd0);
    check("c_rst_in_ready", 64'(ifc.in_ready), 64'd1);
    check("c_rst_out_idx", 64'(ifc.out_idx), 64'd0);
    check("c_rst_out_last", 64'(ifc.out_last), 64'd0);
    qc.delete();
    in_valid64 = 1'b1;
    in_mask64  = 64'h10;
    push64(64'h10);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    check("c_accept_after_release", 64'(busy_c), 64'd1);
    in_valid64 = 1'b0;
    drain64();
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("c_no_stale_beats", 64'(ifc.out_valid), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
    $fatal(1);
  end

endmodule
